morse_msg_sequencer: RTL and testbench
======================================

// Module: morse_msg_sequencer
// PURPOSE
//  Buffers a message of 5-bit character codes (1-26 = A-Z, 0 = space) in a FIFO and feeds it,
//  one character per transaction, to the Morse translator's char/start/busy interface.
//  Sits between the host/ui_in and the translator; owns the start strobe and the inter-char guard.
//  Detects a translator that never acknowledges (timeout) and reports per-character completion.
// PARAMETERS
//  DEPTH     16  FIFO entries (power of 2, >=2)
//  ACK_TO    15  max cycles start_out is held high waiting for busy_in before abandoning the char
//  GUARD      2  cycles start_out is held low after a transaction before the next launch (>=1)
// PORTS
//  clk          in   1   clock; single clock domain
//  rst_n        in   1   asynchronous, active-low reset
//  enable       in   1   1 = launch characters while FIFO non-empty; 0 = hold in IDLE
//  push_valid   in   1   write push_char into FIFO this cycle
//  push_char    in   5   character code to enqueue
//  push_ready   out  1   1 = FIFO not full (combinational from count)
//  flush        in   1   synchronous FIFO clear; does not abort an in-flight character
//  busy_in      in   1   translator busy flag
//  char_out     out  5   character presented to translator (registered)
//  start_out    out  1   start strobe to translator (registered)
//  done_pulse   out  1   1-cycle pulse: translator finished a character (busy fell)
//  timeout_err  out  1   1-cycle pulse: ACK_TO expired with no busy_in
//  fifo_count   out  $clog2(DEPTH+1)  entries held
//  seq_idle     out  1   1 = FSM in IDLE
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE; char_out=0, start_out=0, done_pulse=0, timeout_err=0,
//   fifo_count=0, seq_idle=1, push_ready=1. Reset mid-transaction abandons it immediately.
//  FIFO: push accepted iff push_valid && push_ready && !flush; push while full is dropped.
//   Pop occurs only in LOAD. Push+pop same cycle: count unchanged. flush: count<=0, pointers<=0,
//   wins over same-cycle push and pop. Pointers wrap modulo DEPTH.
//  FSM (one state per cycle unless noted):
//   IDLE:     start_out=0. If enable && count>0 -> LOAD.
//   LOAD:     char_out<=FIFO head, pop -> STROBE. (char stable one cycle before start rises)
//   STROBE:   start_out<=1, timer<=0 -> WAIT_ACK.
//   WAIT_ACK: start_out held 1. busy_in==1 -> start_out<=0, -> WAIT_DONE.
//             else timer==ACK_TO-1 -> start_out<=0, timeout_err<=1, -> GUARD. else timer++.
//   WAIT_DONE: busy_in==0 -> done_pulse<=1, -> GUARD. No timeout (word gap can be ~1.75M cycles).
//   GUARD:    start_out=0 for GUARD cycles (timer counts 0..GUARD-1) -> IDLE.
//  Latency: FIFO non-empty in IDLE -> start_out high 2 cycles later (LOAD, STROBE).
//  A 1-cycle busy pulse (invalid code 27-31) is a valid ack; WAIT_DONE then sees busy=0 and
//   completes normally. char_out holds its last value outside LOAD.
//  enable dropping mid-transaction: current char completes; no new LOAD until enable=1.
//  flush mid-transaction: in-flight char completes, remaining chars discarded.
//  done_pulse and timeout_err are never high in the same cycle.
// TESTING
//  1. Push 3,1,19 (C,A,S), enable=1, translator model busy 3 cyc after start for 10 cyc ->
//     char_out 3,1,19 in order, 3 done_pulses, start_out low >=GUARD cycles between strobes.
//  2. Push DEPTH+2 chars with enable=0 -> push_ready=0 after 16, last 2 dropped, fifo_count=16.
//  3. busy_in tied 0, push 5 -> start_out high exactly ACK_TO cycles, one timeout_err, back to IDLE,
//     fifo_count=0.
//  4. Push 30 (invalid), model gives 1-cycle busy -> done_pulse, no timeout_err.
//  5. Push 4 chars, flush during WAIT_DONE of char 1 -> char 1 completes, fifo_count=0, no relaunch.
//  6. Assert rst_n=0 in WAIT_ACK -> start_out=0, fifo_count=0, seq_idle=1 asynchronously.

Source files
------------

// File: rtl/morse_msg_sequencer.sv
// Character FIFO plus launch sequencer for the Morse translator: presents one buffered
// character at a time on char/start, waits for busy to rise and fall, then enforces a guard gap.
module morse_msg_sequencer #(
   parameter int DEPTH  = 16,
   parameter int ACK_TO = 15,
   parameter int GUARD  = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic                         push_valid,
   input  logic [4:0]                   push_char,
   output logic                         push_ready,
   input  logic                         flush,
   input  logic                         busy_in,
   output logic [4:0]                   char_out,
   output logic                         start_out,
   output logic                         done_pulse,
   output logic                         timeout_err,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic                         seq_idle
);

   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int TMR_MAX = (ACK_TO > GUARD) ? ACK_TO : GUARD;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [TMR_W-1:0] ACK_LAST   = TMR_W'(ACK_TO - 1);
   localparam logic [TMR_W-1:0] GUARD_LAST = TMR_W'(GUARD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STROBE,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_GUARD
   } state_t;

   state_t state, state_nxt;

   logic [4:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_en, pop_en, fifo_has_data;

   logic [TMR_W-1:0] timer, timer_nxt;
   logic [4:0]       char_nxt;
   logic             start_nxt, done_nxt, tmo_nxt;

   assign fifo_has_data = (count != '0);
   assign push_ready    = (count != FULL_CNT);
   assign push_en       = push_valid && push_ready && !flush;
   // A flush in the IDLE->LOAD cycle can leave LOAD with an empty FIFO; never pop then.
   assign pop_en        = (state == S_LOAD) && fifo_has_data && !flush;
   assign fifo_count    = count;
   assign seq_idle      = (state == S_IDLE);

   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= push_char;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
         if (push_en && !pop_en)      count <= count + 1'b1;
         else if (pop_en && !push_en) count <= count - 1'b1;
      end
   end

   // State register together with the registered translator-facing outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         timer       <= '0;
         char_out    <= '0;
         start_out   <= 1'b0;
         done_pulse  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         timer       <= timer_nxt;
         char_out    <= char_nxt;
         start_out   <= start_nxt;
         done_pulse  <= done_nxt;
         timeout_err <= tmo_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (enable && fifo_has_data) state_nxt = S_LOAD;
         S_LOAD:      state_nxt = fifo_has_data ? S_STROBE : S_IDLE;
         S_STROBE:    state_nxt = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (busy_in)                state_nxt = S_WAIT_DONE;
            else if (timer == ACK_LAST) state_nxt = S_GUARD;
         end
         // No timeout here: a word gap keeps the translator busy for a very long time.
         S_WAIT_DONE: if (!busy_in) state_nxt = S_GUARD;
         S_GUARD:     if (timer == GUARD_LAST) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      start_nxt = start_out;
      done_nxt  = 1'b0;
      tmo_nxt   = 1'b0;
      timer_nxt = timer;
      char_nxt  = char_out;
      case (state)
         S_IDLE:   start_nxt = 1'b0;
         S_LOAD:   if (fifo_has_data) char_nxt = mem[rd_ptr];
         S_STROBE: begin
            start_nxt = 1'b1;
            timer_nxt = '0;
         end
         S_WAIT_ACK: begin
            if (busy_in) begin
               start_nxt = 1'b0;
            end else if (timer == ACK_LAST) begin
               start_nxt = 1'b0;
               tmo_nxt   = 1'b1;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!busy_in) begin
               done_nxt  = 1'b1;
               timer_nxt = '0;
            end
         end
         S_GUARD: begin
            start_nxt = 1'b0;
            timer_nxt = (timer == GUARD_LAST) ? '0 : timer + 1'b1;
         end
         default: start_nxt = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Directed bench for morse_msg_sequencer: a FIFO vector table plus hand-written
// transaction sequences against a small reactive translator model.
module tb_morse_msg_sequencer;

   localparam int DEPTH  = 16;
   localparam int ACK_TO = 15;
   localparam int GUARD  = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       push_valid = 1'b0;
   logic [4:0] push_char = '0;
   logic       push_ready;
   logic       flush = 1'b0;
   logic       busy_in = 1'b0;
   logic [4:0] char_out;
   logic       start_out;
   logic       done_pulse;
   logic       timeout_err;
   logic [4:0] fifo_count;
   logic       seq_idle;

   morse_msg_sequencer #(.DEPTH(DEPTH), .ACK_TO(ACK_TO), .GUARD(GUARD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .push_valid (push_valid),
      .push_char  (push_char),
      .push_ready (push_ready),
      .flush      (flush),
      .busy_in    (busy_in),
      .char_out   (char_out),
      .start_out  (start_out),
      .done_pulse (done_pulse),
      .timeout_err(timeout_err),
      .fifo_count (fifo_count),
      .seq_idle   (seq_idle)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Translator model: raises busy ack_dly cycles after seeing start, holds it busy_len cycles.
   bit ack_on  = 1'b0;
   int ack_dly = 3;
   int busy_len = 10;
   int mph = 0;
   int mcnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         mph = 0;
         busy_in = 1'b0;
      end else if (mph == 0) begin
         if (ack_on && start_out) begin
            mph = 1;
            mcnt = 1;
         end
      end else if (mph == 1) begin
         if (mcnt >= ack_dly) begin
            busy_in = 1'b1;
            mph = 2;
            mcnt = 1;
         end else mcnt++;
      end else begin
         if (mcnt >= busy_len) begin
            busy_in = 1'b0;
            mph = 0;
         end else mcnt++;
      end
   end

   // Output monitor: launched characters, pulse counts, strobe high/low lengths.
   int q[$];
   int done_cnt = 0, tmo_cnt = 0, both_cnt = 0;
   int hi_len = 0, last_hi = 0, lo_len = 0, min_gap = 1000;
   bit prev_start = 1'b0, seen_fall = 1'b0;

   always begin
      @(posedge clk);
      #1;
      if (start_out && !prev_start) begin
         q.push_back(int'(char_out));
         if (seen_fall && lo_len < min_gap) min_gap = lo_len;
         hi_len = 1;
      end else if (start_out) begin
         hi_len++;
      end else if (prev_start) begin
         last_hi = hi_len;
         lo_len = 1;
         seen_fall = 1'b1;
      end else begin
         lo_len++;
      end
      if (done_pulse) done_cnt++;
      if (timeout_err) tmo_cnt++;
      if (done_pulse && timeout_err) both_cnt++;
      prev_start = start_out;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic bit cond_met(input int sel, input int target);
      case (sel)
         0:       return done_cnt >= target;
         1:       return tmo_cnt >= target;
         2:       return busy_in == 1'b1;
         default: return start_out == 1'b1;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int target, input int budget, input string nm);
      int n = 0;
      while (!cond_met(sel, target) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!cond_met(sel, target)) begin
         checks++;
         errors++;
         $display("FAIL %s: timed out after %0d cycles", nm, budget);
      end
   endtask

   task automatic push(input logic [4:0] c);
      push_valid = 1'b1;
      push_char  = c;
      @(negedge clk);
      push_valid = 1'b0;
   endtask

   typedef struct {
      logic       pv;
      logic [4:0] ch;
      logic       fl;
      int         exp_cnt;
      logic       exp_rdy;
   } vec_t;

   vec_t vecs[22];

   initial begin
      int d0, t0;

      vecs[0] = '{1'b1, 5'd7, 1'b0, 1, 1'b1};
      vecs[1] = '{1'b1, 5'd8, 1'b1, 0, 1'b1};
      vecs[2] = '{1'b0, 5'd0, 1'b1, 0, 1'b1};
      vecs[3] = '{1'b0, 5'd0, 1'b0, 0, 1'b1};
      for (int k = 0; k < 16; k++)
         vecs[4+k] = '{1'b1, 5'(k + 1), 1'b0, k + 1, (k + 1 < 16)};
      vecs[20] = '{1'b1, 5'd17, 1'b0, 16, 1'b0};
      vecs[21] = '{1'b1, 5'd18, 1'b0, 16, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_char_out", char_out, 0);
      chk("rst_start_out", start_out, 0);
      chk("rst_done_pulse", done_pulse, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_seq_idle", seq_idle, 1);
      chk("rst_push_ready", push_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // FIFO table with launching held off: flush priority, fill, overflow drop
      for (int i = 0; i < 22; i++) begin
         push_valid = vecs[i].pv;
         push_char  = vecs[i].ch;
         flush      = vecs[i].fl;
         @(negedge clk);
         chk($sformatf("vec%0d_count", i), fifo_count, vecs[i].exp_cnt);
         chk($sformatf("vec%0d_ready", i), push_ready, vecs[i].exp_rdy);
      end
      push_valid = 1'b0;
      flush = 1'b0;
      chk("full_not_launched", seq_idle, 1);

      // Drain the full FIFO: order 1..16, the two overflow pushes never appear
      q.delete();
      d0 = done_cnt;
      ack_on = 1'b1; ack_dly = 1; busy_len = 1;
      enable = 1'b1;
      wait_for(0, d0 + 16, 1000, "drain_done");
      enable = 1'b0;
      repeat (4) @(negedge clk);
      chk("drain_n", q.size(), 16);
      for (int k = 0; k < 16; k++)
         chk($sformatf("drain_char%0d", k), (k < q.size()) ? q[k] : 99, k + 1);
      chk("drain_count", fifo_count, 0);

      // Message C,A,S with a 3-cycle ack and 10-cycle busy
      q.delete();
      min_gap = 1000;
      d0 = done_cnt; t0 = tmo_cnt;
      ack_dly = 3; busy_len = 10;
      push(5'd3); push(5'd1); push(5'd19);
      enable = 1'b1;
      wait_for(0, d0 + 3, 400, "t1_done");
      repeat (4) @(negedge clk);
      enable = 1'b0;
      chk("t1_n", q.size(), 3);
      chk("t1_char0", (q.size() > 0) ? q[0] : 99, 3);
      chk("t1_char1", (q.size() > 1) ? q[1] : 99, 1);
      chk("t1_char2", (q.size() > 2) ? q[2] : 99, 19);
      chk("t1_dones", done_cnt - d0, 3);
      chk("t1_no_tmo", tmo_cnt - t0, 0);
      chk("t1_gap_ge_guard", min_gap >= GUARD, 1);
      chk("t1_idle", seq_idle, 1);
      chk("t1_count", fifo_count, 0);

      // Dead translator: start held exactly ACK_TO cycles, one timeout
      q.delete();
      d0 = done_cnt; t0 = tmo_cnt;
      ack_on = 1'b0;
      push(5'd5);
      enable = 1'b1;
      wait_for(1, t0 + 1, 100, "t3_tmo");
      repeat (4) @(negedge clk);
      enable = 1'b0;
      chk("t3_high_len", last_hi, ACK_TO);
      chk("t3_tmo_pulses", tmo_cnt - t0, 1);
      chk("t3_no_done", done_cnt - d0, 0);
      chk("t3_char", (q.size() > 0) ? q[0] : 99, 5);
      chk("t3_idle", seq_idle, 1);
      chk("t3_count", fifo_count, 0);

      // Invalid code with a single-cycle busy pulse still completes
      q.delete();
      d0 = done_cnt; t0 = tmo_cnt;
      ack_on = 1'b1; ack_dly = 1; busy_len = 1;
      push(5'd30);
      enable = 1'b1;
      wait_for(0, d0 + 1, 100, "t4_done");
      repeat (4) @(negedge clk);
      enable = 1'b0;
      chk("t4_dones", done_cnt - d0, 1);
      chk("t4_no_tmo", tmo_cnt - t0, 0);
      chk("t4_char", (q.size() > 0) ? q[0] : 99, 30);

      // Flush while the first of four characters is being sent
      q.delete();
      d0 = done_cnt;
      ack_dly = 3; busy_len = 10;
      push(5'd1); push(5'd2); push(5'd3); push(5'd4);
      enable = 1'b1;
      wait_for(2, 0, 100, "t5_busy");
      repeat (2) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("t5_flushed_count", fifo_count, 0);
      wait_for(0, d0 + 1, 100, "t5_done");
      repeat (20) @(negedge clk);
      chk("t5_strobes", q.size(), 1);
      chk("t5_char", (q.size() > 0) ? q[0] : 99, 1);
      chk("t5_dones", done_cnt - d0, 1);
      chk("t5_idle", seq_idle, 1);
      enable = 1'b0;

      // Asynchronous reset while waiting for the ack
      ack_on = 1'b0;
      push(5'd9); push(5'd10);
      enable = 1'b1;
      wait_for(3, 0, 100, "t6_start");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_start_out", start_out, 0);
      chk("t6_count", fifo_count, 0);
      chk("t6_idle", seq_idle, 1);
      chk("t6_ready", push_ready, 1);
      chk("t6_char_out", char_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_stays_idle", seq_idle, 1);
      enable = 1'b0;

      chk("pulses_exclusive", both_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
